sync_fifo_ctl: RTL and testbench



---
 rtl/sync_fifo_ctl.sv | 73 +++++++
 tb/tb_sync_fifo_ctl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with count, almost flags and sticky errors; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_ctl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int AFULL_TH = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY = AEMPTY_TH[ASIZE:0];
  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d, we, re;
  assign wfull = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign rempty = wptr_q == rptr_q;
  assign walmost_full = count_q >= AFULL;
  assign ralmost_empty = count_q <= AEMPTY;
  assign count = count_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    we = winc && !wfull;
    re = rinc && !rempty;
    wptr_d = wptr_q + (ASIZE+1)'(we);
    rptr_d = rptr_q + (ASIZE+1)'(re);
    count_d = count_q + (ASIZE+1)'(we) - (ASIZE+1)'(re);
    overflow_d = overflow_q || (winc && wfull);
    underflow_d = underflow_q || (rinc && rempty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q[ASIZE-1:0]] <= wdata;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;
  assign rdata_d = re ? mem[rptr_q[ASIZE-1:0]] : rdata_q;
  assign rdata = rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
`endif
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: scoreboard bench for sync_fifo_ctl at default parameters, both read modes
module tb_sync_fifo_ctl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] wdata = '0;
  logic winc = 1'b0;
  logic rinc = 1'b0;
  logic wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];
  int mcount = 0;
  logic movf = 1'b0;
  logic mudf = 1'b0;
  logic [7:0] mrdata = '0;

  sync_fifo_ctl dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(mcount));
    check("wfull", 32'(wfull), 32'(mcount == 16));
    check("rempty", 32'(rempty), 32'(mcount == 0));
    check("walmost_full", 32'(walmost_full), 32'(mcount >= 12));
    check("ralmost_empty", 32'(ralmost_empty), 32'(mcount <= 4));
    check("overflow", 32'(overflow), 32'(movf));
    check("underflow", 32'(underflow), 32'(mudf));
  endtask

  task automatic cycle(input logic w, input logic [7:0] wd, input logic r);
    logic wacc, racc;
    logic [7:0] exp;
    winc = w;
    wdata = wd;
    rinc = r;
    wacc = w && mcount != 16;
    racc = r && mcount != 0;
    if (w && mcount == 16) movf = 1'b1;
    if (r && mcount == 0) mudf = 1'b1;
    if (racc) begin
      exp = sb.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      check("rdata_fwft", 32'(rdata), 32'(exp));
`else
      mrdata = exp;
`endif
    end
    if (wacc) sb.push_back(wd);
    mcount = mcount + int'(wacc) - int'(racc);
    @(posedge clk);
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    check("rdata", 32'(rdata), 32'(mrdata));
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    check("rdata_reset", 32'(rdata), 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 1; i <= 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    while (mcount > 0) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    check("count_before_reset", 32'(count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    movf = 1'b0;
    mudf = 1'b0;
    mrdata = '0;
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    check("rdata_async_reset", 32'(rdata), 32'h0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h4D, 1'b0);
    cycle(1'b1, 8'h5E, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
